// File: rtl/module_b_endpoint.sv
// B-side link endpoint: a DEPTH-entry input FIFO feeds a registered output stage.
// Each word is transformed by the runtime-selected mode as it moves into the output stage.
module module_b_endpoint #(
    parameter int FROM_A_WIDTH  = 8,
    parameter int TO_A_WIDTH    = 8,
    parameter int EXTRA_WIDTH   = 4,
    parameter int DEPTH         = 4,
    localparam int LVL_W        = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FROM_A_WIDTH-1:0] data_to_B,
    input  logic                    to_B_valid,
    output logic                    to_B_ready,
    output logic [TO_A_WIDTH-1:0]   data_from_B,
    output logic                    from_B_valid,
    input  logic                    from_B_ready,
    input  logic [1:0]              mode,
    input  logic [EXTRA_WIDTH-1:0]  b_extra_in,
    output logic [EXTRA_WIDTH-1:0]  b_extra_out,
    output logic [LVL_W-1:0]        fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int WW    = (FROM_A_WIDTH > TO_A_WIDTH) ? FROM_A_WIDTH : TO_A_WIDTH;
    localparam int REP   = (TO_A_WIDTH + EXTRA_WIDTH - 1) / EXTRA_WIDTH;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        MODE_LOOP   = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_ACC    = 2'd2,
        MODE_XOR    = 2'd3
    } mode_e;

    logic [FROM_A_WIDTH-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]           wptr;
    logic [PTR_W-1:0]           rptr;
    logic [TO_A_WIDTH-1:0]      acc;
    logic [WW-1:0]              head_ext;
    logic [TO_A_WIDTH-1:0]      w;
    logic [REP*EXTRA_WIDTH-1:0] x_rep;
    logic [TO_A_WIDTH-1:0]      out_word;
    logic                       push;
    logic                       pop;
    logic                       out_free;

    // Readiness comes only from registered occupancy, so a same-cycle pop never frees a slot.
    assign to_B_ready = (fifo_level != FULL_LVL);
    assign push       = to_B_valid && to_B_ready;
    assign out_free   = !from_B_valid || from_B_ready;
    assign pop        = out_free && (fifo_level != '0);

    // Zero-extend or truncate (keeping LSBs) the head word to the output width.
    assign head_ext = WW'(mem[rptr]);
    assign w        = head_ext[TO_A_WIDTH-1:0];
    assign x_rep    = {REP{b_extra_in}};

    always_comb begin
        out_word = w;
        case (mode_e'(mode))
            MODE_LOOP:   out_word = w;
            MODE_INVERT: out_word = ~w;
            MODE_ACC:    out_word = acc + w;
            MODE_XOR:    out_word = w ^ x_rep[TO_A_WIDTH-1:0];
            default:     out_word = w;
        endcase
    end

    // NOTE: the storage array has no reset; the pointers and level alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= data_to_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            fifo_level   <= '0;
            acc          <= '0;
            from_B_valid <= 1'b0;
            data_from_B  <= '0;
            b_extra_out  <= '0;
        end else begin
            b_extra_out <= b_extra_in;
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr         <= rptr + PTR_W'(1);
                data_from_B  <= out_word;
                from_B_valid <= 1'b1;
                if (mode == MODE_ACC) begin
                    acc <= out_word;
                end
            end else if (out_free) begin
                from_B_valid <= 1'b0;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LVL_W'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LVL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_module_b_endpoint.sv
// Directed bench for module_b_endpoint with a 12-bit input and 8-bit output so the
// truncation and sideband-replication paths are exercised alongside the FIFO behaviour.
module tb_module_b_endpoint;

    localparam int FW = 12;
    localparam int TW = 8;
    localparam int EW = 4;
    localparam int D  = 4;
    localparam int LW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] data_to_B;
    logic          to_B_valid;
    logic          to_B_ready;
    logic [TW-1:0] data_from_B;
    logic          from_B_valid;
    logic          from_B_ready;
    logic [1:0]    mode;
    logic [EW-1:0] b_extra_in;
    logic [EW-1:0] b_extra_out;
    logic [LW-1:0] fifo_level;

    int n_cmp = 0;
    int n_err = 0;

    module_b_endpoint #(
        .FROM_A_WIDTH(FW),
        .TO_A_WIDTH  (TW),
        .EXTRA_WIDTH (EW),
        .DEPTH       (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_to_B   (data_to_B),
        .to_B_valid  (to_B_valid),
        .to_B_ready  (to_B_ready),
        .data_from_B (data_from_B),
        .from_B_valid(from_B_valid),
        .from_B_ready(from_B_ready),
        .mode        (mode),
        .b_extra_in  (b_extra_in),
        .b_extra_out (b_extra_out),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic push_word(input logic [FW-1:0] d, input string tag);
        logic accepted;
        accepted   = 1'b0;
        data_to_B  = d;
        to_B_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = to_B_ready;
            step();
        end
        to_B_valid = 1'b0;
        check(tag, 32'(accepted), 32'd1);
    endtask

    // Wait (bounded) for a valid output word and compare it; from_B_ready is assumed high.
    task automatic expect_out(input logic [TW-1:0] exp, input string tag);
        for (int i = 0; i < 10 && !from_B_valid; i++) begin
            step();
        end
        check({tag, "_valid"}, 32'(from_B_valid), 32'd1);
        check({tag, "_data"}, 32'(data_from_B), 32'(exp));
    endtask

    initial begin
        logic [TW-1:0] got_q[$];
        logic          pending;

        // Reset held for two edges while a word is offered.
        rst          = 1'b1;
        to_B_valid   = 1'b1;
        data_to_B    = 12'h0FF;
        from_B_ready = 1'b0;
        mode         = 2'd0;
        b_extra_in   = 4'hC;
        step();
        step();
        rst        = 1'b0;
        to_B_valid = 1'b0;
        b_extra_in = 4'h0;
        check("rst_valid", 32'(from_B_valid), 32'd0);
        check("rst_data", 32'(data_from_B), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_extra", 32'(b_extra_out), 32'd0);
        check("rst_ready", 32'(to_B_ready), 32'd1);

        // Loopback latency: write at edge N, transfer at N+1, one valid cycle.
        from_B_ready = 1'b1;
        data_to_B    = 12'h05A;
        to_B_valid   = 1'b1;
        step();
        to_B_valid = 1'b0;
        check("lat_n_level", 32'(fifo_level), 32'd1);
        check("lat_n_valid", 32'(from_B_valid), 32'd0);
        step();
        check("lat_n1_valid", 32'(from_B_valid), 32'd1);
        check("lat_n1_data", 32'(data_from_B), 32'h5A);
        check("lat_n1_level", 32'(fifo_level), 32'd0);
        step();
        check("lat_n2_valid", 32'(from_B_valid), 32'd0);

        // Backpressure: 01..05 fill output register plus FIFO, 06 stalls.
        from_B_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push_word(12'(k), "bp_push");
        end
        check("bp_level_full", 32'(fifo_level), 32'd4);
        check("bp_ready_low", 32'(to_B_ready), 32'd0);
        check("bp_head", 32'(data_from_B), 32'h01);
        data_to_B  = 12'h006;
        to_B_valid = 1'b1;
        step();
        step();
        check("bp_stall_ready", 32'(to_B_ready), 32'd0);
        check("bp_stall_level", 32'(fifo_level), 32'd4);
        check("bp_stall_head", 32'(data_from_B), 32'h01);

        // Release backpressure and collect the drained stream.
        from_B_ready = 1'b1;
        pending      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic take;
            if (from_B_valid) got_q.push_back(data_from_B);
            take = pending && to_B_ready;
            step();
            if (take) begin
                to_B_valid = 1'b0;
                pending    = 1'b0;
            end
        end
        check("drain_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            check("drain_word", 32'(got_q[i]), 32'(i + 1));
        end
        check("drain_level", 32'(fifo_level), 32'd0);
        check("drain_valid", 32'(from_B_valid), 32'd0);

        // Invert, then accumulate (acc starts at 0; F0 + 20 wraps to 10).
        mode = 2'd1;
        push_word(12'h00F, "inv_push");
        expect_out(8'hF0, "inv");
        mode = 2'd2;
        push_word(12'h0F0, "acc1_push");
        expect_out(8'hF0, "acc1");
        push_word(12'h020, "acc2_push");
        expect_out(8'h10, "acc2");

        // Sideband register timing.
        step();
        b_extra_in = 4'h5;
        step();
        check("extra_5", 32'(b_extra_out), 32'h5);
        b_extra_in = 4'hA;
        check("extra_hold", 32'(b_extra_out), 32'h5);
        step();
        check("extra_a", 32'(b_extra_out), 32'hA);

        // Sideband XOR with truncation: F3C -> 3C, 3C ^ AA = 96.
        mode = 2'd3;
        push_word(12'hF3C, "xor_push");
        expect_out(8'h96, "xor");

        // Mid-operation reset with one word in the output register and three queued.
        step();
        mode         = 2'd0;
        from_B_ready = 1'b0;
        push_word(12'h011, "mr_push");
        push_word(12'h022, "mr_push");
        push_word(12'h033, "mr_push");
        push_word(12'h044, "mr_push");
        check("mr_pre_level", 32'(fifo_level), 32'd3);
        check("mr_pre_valid", 32'(from_B_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_level", 32'(fifo_level), 32'd0);
        check("mr_valid", 32'(from_B_valid), 32'd0);
        check("mr_data", 32'(data_from_B), 32'd0);
        check("mr_ready", 32'(to_B_ready), 32'd1);

        // Accumulate mode after reset proves acc was cleared: 0 + 77 = 77.
        from_B_ready = 1'b1;
        mode         = 2'd2;
        data_to_B    = 12'h077;
        to_B_valid   = 1'b1;
        step();
        to_B_valid = 1'b0;
        check("post_n_valid", 32'(from_B_valid), 32'd0);
        step();
        check("post_valid", 32'(from_B_valid), 32'd1);
        check("post_data", 32'(data_from_B), 32'h77);
        step();
        check("post_no_stale", 32'(from_B_valid), 32'd0);
        check("post_level", 32'(fifo_level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
